// File: rtl/rf_operand_reader.sv
// Operand-fetch stage: reads the 4-entry register file, tracks pending writes, presents operand bundles.
// Optional macro RF_WB_BYPASS_EN forwards the writeback value straight into the captured operands.
module rf_operand_reader #(
    parameter int WORD_SIZE  = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic                  in_use_rs,
    input  logic                  in_use_rt,
    input  logic                  in_wr_en,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
    output logic [REG_ADDR_W-1:0] rf_addr1,
    output logic [REG_ADDR_W-1:0] rf_addr2,
    input  logic [WORD_SIZE-1:0]  rf_data1,
    input  logic [WORD_SIZE-1:0]  rf_data2,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [WORD_SIZE-1:0]  wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_op1,
    output logic [WORD_SIZE-1:0]  out_op2,
    output logic                  out_wr_en,
    output logic [REG_ADDR_W-1:0] out_wr_addr
);

    localparam int NUM_REG = 2 ** REG_ADDR_W;

    logic [NUM_REG-1:0] pending;
    logic [NUM_REG-1:0] pending_next;
    logic               hit_rs;
    logic               hit_rt;
    logic               hit_wr;
    logic               raw_rs;
    logic               raw_rt;
    logic               waw;
    logic               accept;

`ifdef RF_WB_BYPASS_EN
    assign hit_rs = wb_valid && (wb_addr == in_rs);
    assign hit_rt = wb_valid && (wb_addr == in_rt);
    assign hit_wr = wb_valid && (wb_addr == in_wr_addr);
`else
    assign hit_rs = 1'b0;
    assign hit_rt = 1'b0;
    assign hit_wr = 1'b0;
`endif

    // A writeback landing this cycle resolves the hazard only when it can be forwarded.
    assign raw_rs = in_use_rs && pending[in_rs] && !hit_rs;
    assign raw_rt = in_use_rt && pending[in_rt] && !hit_rt;
    assign waw    = in_wr_en && pending[in_wr_addr] && !hit_wr;

    assign in_ready = !reset && !flush && !(raw_rs || raw_rt || waw) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign rf_addr1 = in_rs;
    assign rf_addr2 = in_rt;

    always_comb begin
        // NOTE: default assignment first so every path drives pending_next and no latch is inferred.
        pending_next = pending;
        if (wb_valid)
            pending_next[wb_addr] = 1'b0;
        if (accept && in_wr_en)
            pending_next[in_wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            pending     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            pending   <= '0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                out_valid   <= 1'b1;
                out_op1     <= in_use_rs ? (hit_rs ? wb_data : rf_data1) : '0;
                out_op2     <= in_use_rt ? (hit_rt ? wb_data : rf_data2) : '0;
                out_wr_en   <= in_wr_en;
                out_wr_addr <= in_wr_addr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_operand_reader.sv
// Self-checking bench for rf_operand_reader: directed scenarios plus randomized traffic vs. a register-level model.
module tb_rf_operand_reader;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_rs;
    logic [1:0]  in_rt;
    logic        in_use_rs;
    logic        in_use_rt;
    logic        in_wr_en;
    logic [1:0]  in_wr_addr;
    logic [1:0]  rf_addr1;
    logic [1:0]  rf_addr2;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_op1;
    logic [15:0] out_op2;
    logic        out_wr_en;
    logic [1:0]  out_wr_addr;

    logic [15:0] rf_mem [4];

    // Reference model: the pending-write set and the bundle held for execute.
    bit [3:0]    m_pend;
    bit          m_valid;
    logic [15:0] m_op1;
    logic [15:0] m_op2;
    bit          m_wr_en;
    logic [1:0]  m_wr_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rf_data1 = rf_mem[rf_addr1];
    assign rf_data2 = rf_mem[rf_addr2];

    rf_operand_reader #(.WORD_SIZE(16), .REG_ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
    );

    function automatic bit m_hit(input logic [1:0] a);
        return BYPASS && wb_valid && (wb_addr == a);
    endfunction

    // A register is busy if it has an unretired writer, unless the forwarded writeback covers it now.
    function automatic bit m_busy(input logic [1:0] a);
        return m_pend[a] && !m_hit(a);
    endfunction

    function automatic bit m_ready();
        bit blocked;
        blocked = (in_use_rs && m_busy(in_rs)) || (in_use_rt && m_busy(in_rt)) || (in_wr_en && m_busy(in_wr_addr));
        return !reset && !flush && !blocked && (!m_valid || out_ready);
    endfunction

    // Advance one clock: update model and the environment's register file from pre-edge inputs.
    task automatic tick();
        bit          acc;
        bit [3:0]    np;
        bit          nv;
        logic [15:0] n1;
        logic [15:0] n2;
        bit          nwe;
        logic [1:0]  nwa;
        bit          rf_we;
        logic [1:0]  rf_wa;
        logic [15:0] rf_wd;
        acc = in_valid && m_ready();
        np = m_pend; nv = m_valid; n1 = m_op1; n2 = m_op2; nwe = m_wr_en; nwa = m_wr_addr;
        if (reset) begin
            np = '0; nv = 0; n1 = '0; n2 = '0; nwe = 0; nwa = '0;
        end else if (flush) begin
            np = '0; nv = 0;
        end else begin
            if (wb_valid) np[wb_addr] = 1'b0;
            if (acc) begin
                if (in_wr_en) np[in_wr_addr] = 1'b1;
                nv  = 1;
                n1  = in_use_rs ? (m_hit(in_rs) ? wb_data : rf_mem[in_rs]) : 16'h0;
                n2  = in_use_rt ? (m_hit(in_rt) ? wb_data : rf_mem[in_rt]) : 16'h0;
                nwe = in_wr_en;
                nwa = in_wr_addr;
            end else if (out_ready) begin
                nv = 0;
            end
        end
        rf_we = wb_valid; rf_wa = wb_addr; rf_wd = wb_data;
        @(posedge clk);
        #1;
        m_pend = np; m_valid = nv; m_op1 = n1; m_op2 = n2; m_wr_en = nwe; m_wr_addr = nwa;
        if (rf_we) rf_mem[rf_wa] = rf_wd;
    endtask

    task automatic idle();
        in_valid = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
        in_wr_en = 0; in_wr_addr = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0;
    endtask

    task automatic issue(input logic [1:0] rs, input bit urs, input logic [1:0] rt, input bit urt,
                         input bit we, input logic [1:0] wa);
        in_valid = 1; in_rs = rs; in_use_rs = urs; in_rt = rt; in_use_rt = urt; in_wr_en = we; in_wr_addr = wa;
    endtask

    task automatic test_reset();
        idle(); reset = 1; out_ready = 1; in_valid = 1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tick(); tick();
        reset = 0; in_valid = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if ({out_op1, out_op2} !== 32'h0) begin n_err++; $display("FAIL reset_ops got=%h/%h exp=0/0", out_op1, out_op2); end
        n_vec++; if ({out_wr_en, out_wr_addr} !== 3'b0) begin n_err++; $display("FAIL reset_wr got=%b/%0d exp=0/0", out_wr_en, out_wr_addr); end
    endtask

    task automatic test_basic_read();
        issue(2'd1, 1, 2'd2, 1, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        n_vec++; if ({rf_addr1, rf_addr2} !== 4'b0110) begin n_err++; $display("FAIL basic_rf_addr got=%0d/%0d exp=1/2", rf_addr1, rf_addr2); end
        tick();
        idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        n_vec++; if (out_op1 !== 16'h1234 || out_op2 !== 16'h00FF) begin n_err++; $display("FAIL basic_ops got=%h/%h exp=1234/00ff", out_op1, out_op2); end
        tick();
    endtask

    task automatic test_raw_hazard();
        issue(2'd0, 0, 2'd0, 0, 1, 2'd3);
        tick();
        issue(2'd3, 1, 2'd0, 0, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall got=%b exp=0", in_ready); end
        tick();
        wb_valid = 1; wb_addr = 2'd3; wb_data = 16'hBEEF;
        @(negedge clk);
        n_vec++; if (in_ready !== BYPASS) begin n_err++; $display("FAIL raw_wb_cycle_ready got=%b exp=%b", in_ready, BYPASS); end
        tick();
        wb_valid = 0;
        if (!BYPASS) begin
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_after_wb_ready got=%b exp=1", in_ready); end
            tick();
        end
        idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_op1 !== 16'hBEEF) begin n_err++; $display("FAIL raw_operand got=%b/%h exp=1/beef", out_valid, out_op1); end
        tick();
    endtask

    task automatic test_hold();
        out_ready = 0;
        issue(2'd0, 1, 2'd1, 1, 0, 2'd0);
        tick();
        issue(2'd2, 1, 2'd0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1 || out_op1 !== 16'h0A0A || out_op2 !== 16'h1234)
                begin n_err++; $display("FAIL hold_stable c%0d got=%b/%h/%h exp=1/0a0a/1234", i, out_valid, out_op1, out_op2); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready c%0d got=%b exp=0", i, in_ready); end
            tick();
        end
        out_ready = 1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
        tick();
        idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_op1 !== 16'h00FF || out_op2 !== 16'h0)
            begin n_err++; $display("FAIL hold_next_bundle got=%b/%h/%h exp=1/00ff/0000", out_valid, out_op1, out_op2); end
        tick();
    endtask

    task automatic test_waw();
        issue(2'd0, 0, 2'd0, 0, 1, 2'd2);
        tick();
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall got=%b exp=0", in_ready); end
        tick();
        wb_valid = 1; wb_addr = 2'd2; wb_data = 16'h5555;
        @(negedge clk);
        n_vec++; if (in_ready !== BYPASS) begin n_err++; $display("FAIL waw_wb_cycle_ready got=%b exp=%b", in_ready, BYPASS); end
        tick();
        wb_valid = 0;
        if (!BYPASS) begin
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL waw_after_wb_ready got=%b exp=1", in_ready); end
            tick();
        end
        issue(2'd2, 1, 2'd0, 0, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_still_pending got=%b exp=0", in_ready); end
        idle(); wb_valid = 1; wb_addr = 2'd2; wb_data = 16'h5555;
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush();
        issue(2'd0, 0, 2'd0, 0, 1, 2'd1);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_w1_ready got=%b exp=1", in_ready); end
        tick();
        issue(2'd0, 0, 2'd0, 0, 1, 2'd3);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_w3_back_to_back got=%b exp=1", in_ready); end
        tick();
        idle(); flush = 1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        flush = 0;
        issue(2'd1, 1, 2'd3, 1, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_cleared_ready got=%b exp=1", in_ready); end
        tick();
        idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_op1 !== 16'h1234) begin n_err++; $display("FAIL flush_reader got=%b/%h exp=1/1234", out_valid, out_op1); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 0;
        issue(2'd0, 0, 2'd0, 0, 1, 2'd0);
        tick();
        issue(2'd0, 1, 2'd0, 0, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_pre got=%b/%b exp=1/0", out_valid, in_ready); end
        reset = 1;
        tick();
        reset = 0;
        idle();
        @(negedge clk);
        n_vec++; if ({out_valid, out_op1, out_op2, out_wr_en, out_wr_addr} !== 36'h0)
            begin n_err++; $display("FAIL rmid_outputs got=%b/%h/%h/%b/%0d exp=all zero", out_valid, out_op1, out_op2, out_wr_en, out_wr_addr); end
        out_ready = 1;
        issue(2'd0, 1, 2'd0, 0, 0, 2'd0);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_scoreboard_clear got=%b exp=1", in_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        idle(); reset = 1; tick(); reset = 0;
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(63) == 0);
            flush      = ($urandom_range(15) == 0);
            in_valid   = $urandom_range(1);
            in_rs      = 2'($urandom_range(3));
            in_rt      = 2'($urandom_range(3));
            in_use_rs  = $urandom_range(1);
            in_use_rt  = $urandom_range(1);
            in_wr_en   = $urandom_range(1);
            in_wr_addr = 2'($urandom_range(3));
            wb_valid   = ($urandom_range(2) == 0);
            wb_addr    = 2'($urandom_range(3));
            wb_data    = 16'($urandom);
            out_ready  = ($urandom_range(3) != 0);
            @(negedge clk);
            n_vec++; if (in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_in_ready i=%0d got=%b exp=%b", i, in_ready, m_ready()); end
            n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_out_valid i=%0d got=%b exp=%b", i, out_valid, m_valid); end
            n_vec++; if (out_op1 !== m_op1 || out_op2 !== m_op2)
                begin n_err++; $display("FAIL rnd_ops i=%0d got=%h/%h exp=%h/%h", i, out_op1, out_op2, m_op1, m_op2); end
            n_vec++; if (out_wr_en !== m_wr_en || out_wr_addr !== m_wr_addr)
                begin n_err++; $display("FAIL rnd_wr i=%0d got=%b/%0d exp=%b/%0d", i, out_wr_en, out_wr_addr, m_wr_en, m_wr_addr); end
            n_vec++; if (rf_addr1 !== in_rs || rf_addr2 !== in_rt)
                begin n_err++; $display("FAIL rnd_rf_addr i=%0d got=%0d/%0d exp=%0d/%0d", i, rf_addr1, rf_addr2, in_rs, in_rt); end
            tick();
        end
        idle(); reset = 0;
    endtask

    initial begin
        rf_mem[0] = 16'h0A0A; rf_mem[1] = 16'h1234; rf_mem[2] = 16'h00FF; rf_mem[3] = 16'h0003;
        m_pend = '0; m_valid = 0; m_op1 = '0; m_op2 = '0; m_wr_en = 0; m_wr_addr = '0;
        idle(); reset = 1; out_ready = 1;
        @(posedge clk); #1;
        test_reset();
        test_basic_read();
        test_raw_hazard();
        test_hold();
        test_waw();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
